// File: rtl/csr_trap_unit_if.sv
// Execute-stage <-> CSR/trap unit bus: instruction fields in, read data and PC redirect out.
interface csr_trap_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            valid;
    logic            is_system;
    logic [2:0]      func3;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] src;
    logic            src_idx_zero;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_taken;
    logic            illegal;

    modport master (
        output valid, is_system, func3, csr_addr, src, src_idx_zero, pc,
        input  rdata, redirect, redirect_pc, trap_taken, illegal
    );

    modport slave (
        input  valid, is_system, func3, csr_addr, src, src_idx_zero, pc,
        output rdata, redirect, redirect_pc, trap_taken, illegal
    );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file, ecall/mret/timer-interrupt trap sequencer and prescaled mtime.
// Define CSR_COUNTERS_EN to add the mcycle (0xB00) and minstret (0xB02) counters.
module csr_trap_unit #(
    parameter int unsigned XLEN        = 64,
    parameter logic [63:0] MSTATUS_RST = 64'ha0000_1800,
    parameter logic [63:0] MTVEC_RST   = 64'h0,
    parameter int unsigned MTIME_DIV   = 1
) (
    input logic             clk,
    input logic             rst,
    csr_trap_unit_if.slave  bus
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MTIMECMP = 12'h7C0;
    localparam logic [11:0] A_MTIME    = 12'h7C1;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MRET     = 12'h302;
    localparam int unsigned PW = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
    localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
    localparam logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11);
    localparam logic [XLEN-1:0] LOW2_MASK = ~XLEN'(3);

    logic            mst_mie, mst_mpie;
    logic [1:0]      mst_mpp;
    logic            mtie;
    logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q;
    logic [63:0]     mtime_q, mtimecmp_q;
    logic [PW-1:0]   presc_q;
`ifdef CSR_COUNTERS_EN
    logic [63:0]     mcycle_q, minstret_q;
`endif

    logic            mtip, tick, known;
    logic [XLEN-1:0] mstatus_rd, csr_val, wdata;
    logic            sys_ok, csr_fn, irq, ecall, mret, csr_wr;

    assign mtip = (mtime_q >= mtimecmp_q);
    assign tick = (presc_q == PW'(MTIME_DIV - 1));

    always_comb begin
        mstatus_rd        = MSTATUS_RST[XLEN-1:0];
        mstatus_rd[3]     = mst_mie;
        mstatus_rd[7]     = mst_mpie;
        mstatus_rd[12:11] = mst_mpp;
    end

    always_comb begin
        known   = 1'b1;
        csr_val = '0;
        case (bus.csr_addr)
            A_MSTATUS:  csr_val = mstatus_rd;
            A_MIE:      csr_val[7] = mtie;
            A_MTVEC:    csr_val = mtvec_q;
            A_MEPC:     csr_val = mepc_q;
            A_MCAUSE:   csr_val = mcause_q;
            A_MIP:      csr_val[7] = mtip;
            A_MTIMECMP: csr_val = mtimecmp_q[XLEN-1:0];
            A_MTIME:    csr_val = mtime_q[XLEN-1:0];
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:   csr_val = mcycle_q[XLEN-1:0];
            A_MINSTRET: csr_val = minstret_q[XLEN-1:0];
`endif
            default:    known = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.func3[1:0])
            2'b10:   wdata = csr_val | bus.src;
            2'b11:   wdata = csr_val & ~bus.src;
            default: wdata = bus.src;
        endcase
    end

    // Interrupt entry outranks everything: it discards the committing instruction.
    assign sys_ok = bus.valid & bus.is_system & ~rst;
    assign csr_fn = (bus.func3 != 3'b000);
    assign irq    = bus.valid & ~rst & mst_mie & mtie & mtip;
    assign ecall  = sys_ok & ~csr_fn & (bus.csr_addr == 12'h000) & ~irq;
    assign mret   = sys_ok & ~csr_fn & (bus.csr_addr == A_MRET) & ~irq;
    assign csr_wr = sys_ok & csr_fn & known & ~irq
                  & ((bus.func3[1:0] == 2'b01) | (bus.func3[1] & ~bus.src_idx_zero));

    assign bus.rdata       = csr_fn ? csr_val : '0;
    assign bus.illegal     = sys_ok & csr_fn & ~known;
    assign bus.trap_taken  = irq | ecall;
    assign bus.redirect    = irq | ecall | mret;
    assign bus.redirect_pc = mret ? mepc_q : mtvec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie    <= MSTATUS_RST[3];
            mst_mpie   <= MSTATUS_RST[7];
            mst_mpp    <= MSTATUS_RST[12:11];
            mtie       <= 1'b0;
            mtvec_q    <= MTVEC_RST[XLEN-1:0] & LOW2_MASK;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
        end else begin
            if (irq | ecall) begin
                mepc_q   <= bus.pc & LOW2_MASK;
                mcause_q <= irq ? IRQ_CAUSE : ECALL_CAUSE;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
                mst_mpp  <= 2'b11;
            end else if (mret) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
                mst_mpp  <= 2'b11;
            end else if (csr_wr) begin
                case (bus.csr_addr)
                    A_MSTATUS: begin
                        mst_mie  <= wdata[3];
                        mst_mpie <= wdata[7];
                        mst_mpp  <= wdata[12:11];
                    end
                    A_MIE:      mtie       <= wdata[7];
                    A_MTVEC:    mtvec_q    <= wdata & LOW2_MASK;
                    A_MEPC:     mepc_q     <= wdata & LOW2_MASK;
                    A_MCAUSE:   mcause_q   <= wdata;
                    A_MTIMECMP: mtimecmp_q <= 64'(wdata);
                    default: ;
                endcase
            end

            // A software mtime write beats a same-cycle tick and restarts the prescaler.
            if (csr_wr && bus.csr_addr == A_MTIME) begin
                mtime_q <= 64'(wdata);
                presc_q <= '0;
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (csr_wr && bus.csr_addr == A_MCYCLE) mcycle_q <= 64'(wdata);
            else                                    mcycle_q <= mcycle_q + 64'd1;
            if (csr_wr && bus.csr_addr == A_MINSTRET) minstret_q <= 64'(wdata);
            else if (bus.valid && !irq)               minstret_q <= minstret_q + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: directed commits push expectations, a negedge monitor checks them.
module tb_csr_trap_unit;
    localparam int unsigned XLEN = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_trap_unit_if #(.XLEN(XLEN)) bus ();

    csr_trap_unit #(
        .XLEN(XLEN),
        .MSTATUS_RST(64'ha0000_1800),
        .MTVEC_RST(64'h0),
        .MTIME_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // flags = {redirect, trap_taken, illegal}
    typedef struct {
        string       name;
        int          cyc;
        logic [63:0] rdata;
        bit          chk_rdata;
        logic [63:0] rpc;
        logic [2:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [2:0] gf;
        bit         ok;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            gf = {bus.redirect, bus.trap_taken, bus.illegal};
            ok = (e.cyc == cyc) && (gf == e.flags)
               && (!e.chk_rdata || bus.rdata == e.rdata)
               && (!e.flags[2] || bus.redirect_pc == e.rpc);
            if (!ok) begin
                errors++;
                $display("FAIL %s: got rdata=%h flags=%b redirect_pc=%h, want rdata=%h flags=%b redirect_pc=%h (cycle %0d/%0d)",
                         e.name, bus.rdata, gf, bus.redirect_pc, e.rdata, e.flags, e.rpc, cyc, e.cyc);
            end
        end
    end

    task automatic issue(input string name, input bit v, input logic [2:0] f3, input logic [11:0] a,
                         input logic [63:0] s, input bit z, input logic [63:0] p,
                         input bit chk, input logic [63:0] er, input logic [2:0] ef, input logic [63:0] erpc);
        exp_t e;
        bus.valid        = v;
        bus.is_system    = v;
        bus.func3        = f3;
        bus.csr_addr     = a;
        bus.src          = s;
        bus.src_idx_zero = z;
        bus.pc           = p;
        e.name      = name;
        e.cyc       = cyc;
        e.rdata     = er;
        e.chk_rdata = chk;
        e.rpc       = erpc;
        e.flags     = ef;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic csr(input string name, input logic [2:0] f3, input logic [11:0] a,
                       input logic [63:0] s, input logic [63:0] er);
        issue(name, 1'b1, f3, a, s, (s == 64'd0), 64'd0, 1'b1, er, 3'b000, 64'd0);
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [63:0] er);
        issue(name, 1'b1, 3'b010, a, 64'd0, 1'b1, 64'd0, 1'b1, er, 3'b000, 64'd0);
    endtask

    task automatic idle(input int n);
        bus.valid     = 1'b0;
        bus.is_system = 1'b0;
        bus.func3     = 3'b000;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.valid = 1'b0; bus.is_system = 1'b0; bus.func3 = '0; bus.csr_addr = '0;
        bus.src = '0; bus.src_idx_zero = 1'b1; bus.pc = '0;
        @(posedge clk); #1;
        // An ecall and an unknown-CSR access while in reset must produce no trap/redirect/illegal.
        issue("rst_ecall", 1'b1, 3'b000, 12'h000, 64'd0, 1'b1, 64'h40, 1'b1, 64'd0, 3'b000, 64'd0);
        issue("rst_ill", 1'b1, 3'b001, 12'h7FF, 64'd5, 1'b0, 64'd0, 1'b1, 64'd0, 3'b000, 64'd0);
        rst = 1'b0;

        rd("rst_mstatus", 12'h300, 64'ha0000_1800);
        rd("rst_mtimecmp", 12'h7C0, 64'hFFFF_FFFF_FFFF_FFFF);
        rd("rst_mtvec", 12'h305, 64'd0);
        rd("rst_mie", 12'h304, 64'd0);
        rd("rst_mcause", 12'h342, 64'd0);

        csr("mtvec_wr", 3'b001, 12'h305, 64'h8000_0103, 64'd0);
        rd("mtvec_rd", 12'h305, 64'h8000_0100);
        csr("mstatus_wr", 3'b001, 12'h300, 64'h1808, 64'ha0000_1800);
        rd("mstatus_rd", 12'h300, 64'ha0000_1808);

        issue("ecall", 1'b1, 3'b000, 12'h000, 64'd0, 1'b1, 64'h8000_0040, 1'b1, 64'd0, 3'b110, 64'h8000_0100);
        rd("ecall_mepc", 12'h341, 64'h8000_0040);
        rd("ecall_mcause", 12'h342, 64'd11);
        rd("ecall_mstatus", 12'h300, 64'ha0000_1880);
        issue("mret", 1'b1, 3'b000, 12'h302, 64'd0, 1'b1, 64'h8000_0100, 1'b1, 64'd0, 3'b100, 64'h8000_0040);
        rd("mret_mstatus", 12'h300, 64'ha0000_1888);

        issue("ill_rd", 1'b1, 3'b010, 12'h7FF, 64'd0, 1'b1, 64'd0, 1'b1, 64'd0, 3'b001, 64'd0);
        issue("ill_wr", 1'b1, 3'b001, 12'h7FF, 64'd5, 1'b0, 64'd0, 1'b1, 64'd0, 3'b001, 64'd0);
        rd("ill_nochg", 12'h305, 64'h8000_0100);

        csr("mie_rw", 3'b001, 12'h304, 64'hFFFF, 64'd0);
        rd("mie_rd1", 12'h304, 64'h80);
        csr("mie_rc", 3'b011, 12'h304, 64'h80, 64'h80);
        rd("mie_rd2", 12'h304, 64'd0);
        issue("mie_rs_zero", 1'b1, 3'b010, 12'h304, 64'h80, 1'b1, 64'd0, 1'b1, 64'd0, 3'b000, 64'd0);
        rd("mie_rd3", 12'h304, 64'd0);

        // Timer interrupt: mtime restarted at 0 with MTIME_DIV=4 reaches mtimecmp=10 after 40 edges.
        csr("clr_mie", 3'b011, 12'h300, 64'h8, 64'ha0000_1888);
        csr("mtimecmp_wr", 3'b001, 12'h7C0, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF);
        csr("mtie_rsi", 3'b110, 12'h304, 64'h80, 64'd0);
        issue("mtime_wr", 1'b1, 3'b001, 12'h7C1, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0, 3'b000, 64'd0);
        csr("set_mie", 3'b010, 12'h300, 64'h8, 64'ha0000_1880);
        idle(37);
        rd("mtime_38", 12'h7C1, 64'd9);
        rd("mip_pre", 12'h344, 64'd0);
        issue("irq", 1'b1, 3'b001, 12'h305, 64'h1234, 1'b0, 64'h8000_0200, 1'b1, 64'h8000_0100, 3'b110, 64'h8000_0100);
        rd("irq_mepc", 12'h341, 64'h8000_0200);
        rd("irq_mcause", 12'h342, 64'h8000_0000_0000_0007);
        rd("irq_suppr", 12'h305, 64'h8000_0100);
        rd("irq_mstatus", 12'h300, 64'ha0000_1880);
        rd("mip_set", 12'h344, 64'h80);

        // Reset in the middle of a prescale period.
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rd("mtime_rst", 12'h7C1, 64'd0);
        idle(2);
        rd("presc_rst3", 12'h7C1, 64'd0);
        rd("presc_rst4", 12'h7C1, 64'd1);
        rd("rst2_mstatus", 12'h300, 64'ha0000_1800);

`ifdef CSR_COUNTERS_EN
        csr("cnt_cmp", 3'b001, 12'h7C0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        csr("cnt_mie", 3'b001, 12'h304, 64'h80, 64'd0);
        issue("mcycle_wr", 1'b1, 3'b001, 12'hB00, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0, 3'b000, 64'd0);
        issue("minstret_wr", 1'b1, 3'b001, 12'hB02, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0, 3'b000, 64'd0);
        csr("cnt_c1", 3'b010, 12'h300, 64'h8, 64'ha0000_1800);
        issue("cnt_irq", 1'b1, 3'b010, 12'h304, 64'd0, 1'b1, 64'h100, 1'b1, 64'h80, 3'b110, 64'd0);
        rd("cnt_mcause", 12'h342, 64'h8000_0000_0000_0007);
        rd("cnt_mepc", 12'h341, 64'h100);
        rd("cnt_mstatus", 12'h300, 64'ha0000_1880);
        rd("minstret", 12'hB02, 64'd4);
        rd("mcycle", 12'hB00, 64'd7);
`else
        issue("b00_ill", 1'b1, 3'b010, 12'hB00, 64'd0, 1'b1, 64'd0, 1'b1, 64'd0, 3'b001, 64'd0);
        issue("b02_ill", 1'b1, 3'b001, 12'hB02, 64'd3, 1'b0, 64'd0, 1'b1, 64'd0, 3'b001, 64'd0);
`endif

        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want completion");
        $fatal(1, "timeout");
    end
endmodule
